hex_display_arbiter: RTL and testbench

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

---
 rtl/hex_pkg.sv | 12 +
 rtl/hex_decoder.sv | 33 +++
 rtl/hex_display_arbiter.sv | 174 +++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// Shared types and constants for the hex display arbiter slice.
// Used by hex_decoder and hex_display_arbiter.
package hex_pkg;

  localparam int SEG_W = 7;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [0:0] state_t;
  localparam state_t SHOW_SCORE = 1'b0;
  localparam state_t SHOW_DBG   = 1'b1;

endpackage

// File: rtl/hex_decoder.sv
// Nibble to active-low seven-segment decoder, segment order gfedcba.
// Purely combinational; the top level registers the result.
module hex_decoder
  import hex_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  // Standard hex glyphs, lower-case b and d to stay distinct from 8 and 0
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Arbitrates a score value and a timed debug value onto six seven-segment digits.
// Define HEX_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module hex_display_arbiter
  import hex_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    score_valid,
  input  logic [4*DIGITS-1:0]     score_data,
  output logic                    score_ready,
  input  logic                    dbg_valid,
  input  logic [4*DIGITS-1:0]     dbg_data,
  output logic                    dbg_ready,
  input  logic                    blink_en,
  output logic                    owner,
  output logic [SEG_W*DIGITS-1:0] hex_out
);

  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [31:0]               hold_cnt_r;
  logic [31:0]               hold_nxt_s;
  logic [31:0]               blink_cnt_r;
  logic                      phase_on_r;
  logic [4*DIGITS-1:0]       score_reg_r;
  logic [4*DIGITS-1:0]       dbg_reg_r;
  logic                      score_ready_r;
  logic                      dbg_ready_r;
  logic [SEG_W*DIGITS-1:0]   hex_out_r;
  logic                      dbg_load_s;
  logic                      score_load_s;
  logic [4*DIGITS-1:0]       sel_s;
  logic [SEG_W*DIGITS-1:0]   dec_s;
  logic [SEG_W*DIGITS-1:0]   disp_s;
  logic [SEG_W*DIGITS-1:0]   frame_s;

  assign score_load_s = score_valid & score_ready_r;

  // Ownership FSM: a debug capture starts a fixed-length hold, then score regains the display
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_cnt_r;
    dbg_load_s  = 1'b0;
    case (state_r)
      SHOW_SCORE: begin
        hold_nxt_s = 32'd0;
        if (dbg_valid && dbg_ready_r) begin
          dbg_load_s  = 1'b1;
          state_nxt_s = SHOW_DBG;
        end else begin
          state_nxt_s = SHOW_SCORE;
        end
      end
      SHOW_DBG: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s = SHOW_SCORE;
          hold_nxt_s  = 32'd0;
        end else begin
          hold_nxt_s  = hold_cnt_r + 32'd1;
        end
      end
      default: begin
        state_nxt_s = SHOW_SCORE;
        hold_nxt_s  = 32'd0;
      end
    endcase
  end

  // Value presented to the decoders follows the current owner
  always_comb begin
    if (state_r == SHOW_DBG) begin
      sel_s = dbg_reg_r;
    end else begin
      sel_s = score_reg_r;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      hex_decoder u_dec (
        .nibble (sel_s[4*gi +: 4]),
        .seg    (dec_s[SEG_W*gi +: SEG_W])
      );
    end
  endgenerate

  // Optional leading-zero suppression, scanning from the most significant digit down
  always_comb begin
    disp_s = dec_s;
`ifdef HEX_LZ_BLANK_EN
    begin : lz_scan
      logic seen_s;
      seen_s = 1'b0;
      for (int n = DIGITS - 1; n >= 1; n--) begin
        if (sel_s[4*n +: 4] != 4'h0) begin
          seen_s = 1'b1;
        end else begin
          seen_s = seen_s;
        end
        if (seen_s) begin
          disp_s[SEG_W*n +: SEG_W] = dec_s[SEG_W*n +: SEG_W];
        end else begin
          disp_s[SEG_W*n +: SEG_W] = SEG_BLANK;
        end
      end
    end
`else
    disp_s = dec_s;
`endif
  end

  // Blink off-phase overrides every digit
  always_comb begin
    if (blink_en && !phase_on_r) begin
      frame_s = {DIGITS{SEG_BLANK}};
    end else begin
      frame_s = disp_s;
    end
  end

  // Control state, value registers and handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= SHOW_SCORE;
      hold_cnt_r    <= 32'd0;
      score_reg_r   <= '0;
      dbg_reg_r     <= '0;
      score_ready_r <= 1'b0;
      dbg_ready_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      hold_cnt_r    <= hold_nxt_s;
      score_ready_r <= 1'b1;
      dbg_ready_r   <= (state_nxt_s == SHOW_SCORE);
      if (score_load_s) begin
        score_reg_r <= score_data;
      end
      if (dbg_load_s) begin
        dbg_reg_r <= dbg_data;
      end
    end
  end

  // Free-running blink timebase and the registered display frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_r <= 32'd0;
      phase_on_r  <= 1'b1;
      hex_out_r   <= {DIGITS{SEG_BLANK}};
    end else begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= 32'd0;
        phase_on_r  <= ~phase_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 32'd1;
      end
      hex_out_r <= frame_s;
    end
  end

  assign score_ready = score_ready_r;
  assign dbg_ready   = dbg_ready_r;
  assign owner       = state_r;
  assign hex_out     = hex_out_r;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a monitor pops and compares.
module tb_hex_display_arbiter;

  localparam int HOLD  = 8;
  localparam int BLINK = 4;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_F     = {6{7'h0E}};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        score_valid = 1'b0;
  logic [23:0] score_data = 24'h0;
  logic        score_ready;
  logic        dbg_valid = 1'b0;
  logic [23:0] dbg_data = 24'h0;
  logic        dbg_ready;
  logic        blink_en = 1'b0;
  logic        owner;
  logic [41:0] hex_out;

  hex_display_arbiter #(.DIGITS(6), .HOLD_CYCLES(HOLD), .BLINK_HALF(BLINK)) dut (
    .clk(clk), .resetn(resetn),
    .score_valid(score_valid), .score_data(score_data), .score_ready(score_ready),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .blink_en(blink_en), .owner(owner), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mask bits: 0 hex, 1 owner, 2 score_ready, 3 dbg_ready; at = -1 means check immediately
  typedef struct {
    int          at;
    logic [41:0] hex;
    logic        own;
    logic        sr;
    logic        dr;
    logic [3:0]  m;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event async_ev;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [41:0] disp(input logic [23:0] v);
    logic [41:0] r;
    logic        seen;
    seen = 1'b0;
    r[6:0] = seg7(v[3:0]);
    for (int n = 5; n >= 1; n--) begin
      if (v[4*n +: 4] != 4'h0) seen = 1'b1;
`ifdef HEX_LZ_BLANK_EN
      r[7*n +: 7] = seen ? seg7(v[4*n +: 4]) : 7'h7F;
`else
      r[7*n +: 7] = seg7(v[4*n +: 4]);
`endif
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [41:0] act, input logic [41:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.m[0]) cmp({e.name, "/hex_out"}, hex_out, e.hex);
    if (e.m[1]) cmp({e.name, "/owner"}, {41'd0, owner}, {41'd0, e.own});
    if (e.m[2]) cmp({e.name, "/score_ready"}, {41'd0, score_ready}, {41'd0, e.sr});
    if (e.m[3]) cmp({e.name, "/dbg_ready"}, {41'd0, dbg_ready}, {41'd0, e.dr});
  endtask

  // Monitor: sole owner of the counters
  initial begin
    forever begin
      @(negedge clk or async_ev);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].at == -1 || (q[i].at == cyc && clk == 1'b0)) begin
          check_entry(q[i]);
          q.delete(i);
        end else if (q[i].at >= 0 && q[i].at < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", q[i].name, q[i].at, cyc);
          q.delete(i);
        end
      end
    end
  end

  task automatic push_exp(input int dc, input string name, input logic [41:0] h,
                          input logic o, input logic sr, input logic dr, input logic [3:0] m);
    exp_t e;
    e.at = (dc < 0) ? -1 : cyc + dc;
    e.hex = h; e.own = o; e.sr = sr; e.dr = dr; e.m = m; e.name = name;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic now_check();
    #1;
    -> async_ev;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    push_exp(1, "reset", ALL_BLANK, 1'b0, 1'b0, 1'b0, 4'hF);
    @(negedge clk);
    resetn = 1'b1;
    push_exp(1, "idle", disp(24'h0), 1'b0, 1'b1, 1'b1, 4'hF);
    cycles(1);

    // score 000123
    score_valid = 1'b1; score_data = 24'h000123;
    push_exp(-1, "score_hs", '0, 1'b0, 1'b1, 1'b1, 4'b1100);
    push_exp(2, "score123", disp(24'h000123), 1'b0, 1'b0, 1'b0, 4'b0011);
    now_check();
    cycles(1);
    score_valid = 1'b0;
    cycles(2);

    // debug FFFFFF and hold expiry
    dbg_valid = 1'b1; dbg_data = 24'hFFFFFF;
    push_exp(-1, "dbg_hs", '0, 1'b0, 1'b0, 1'b1, 4'b1000);
    push_exp(1, "dbg_take", '0, 1'b1, 1'b0, 1'b0, 4'b1010);
    push_exp(2, "dbg_ffff", ALL_F, 1'b1, 1'b0, 1'b0, 4'b0011);
    push_exp(HOLD, "dbg_hold_end", ALL_F, 1'b1, 1'b0, 1'b0, 4'b0011);
    push_exp(HOLD + 1, "dbg_release", ALL_F, 1'b0, 1'b0, 1'b1, 4'b1011);
    push_exp(HOLD + 2, "score_back", disp(24'h000123), 1'b0, 1'b0, 1'b0, 4'b0011);
    now_check();
    cycles(1);
    dbg_valid = 1'b0;
    cycles(HOLD + 2);

    // score arriving during debug hold stays hidden until expiry
    dbg_valid = 1'b1; dbg_data = 24'h4E7B2D;
    push_exp(2, "dbg_4e7b2d", disp(24'h4E7B2D), 1'b1, 1'b0, 1'b0, 4'b0011);
    cycles(1);
    dbg_valid = 1'b0;
    cycles(2);
    score_valid = 1'b1; score_data = 24'h000009;
    push_exp(-1, "score_in_dbg", '0, 1'b0, 1'b1, 1'b0, 4'b1100);
    push_exp(2, "hidden_score", disp(24'h4E7B2D), 1'b1, 1'b0, 1'b0, 4'b0011);
    push_exp(HOLD - 3, "hidden_end", disp(24'h4E7B2D), 1'b1, 1'b0, 1'b0, 4'b0011);
    push_exp(HOLD - 2, "own_back", '0, 1'b0, 1'b0, 1'b0, 4'b0010);
    push_exp(HOLD - 1, "score9", disp(24'h000009), 1'b0, 1'b0, 1'b0, 4'b0011);
    now_check();
    cycles(1);
    score_valid = 1'b0;
    cycles(HOLD);

    // simultaneous score and debug transfers
    score_valid = 1'b1; score_data = 24'h000001;
    dbg_valid = 1'b1; dbg_data = 24'h000008;
    push_exp(1, "both_own", '0, 1'b1, 1'b0, 1'b0, 4'b0010);
    push_exp(2, "both_dbg8", disp(24'h000008), 1'b1, 1'b0, 1'b0, 4'b0011);
    push_exp(HOLD + 1, "both_own0", '0, 1'b0, 1'b0, 1'b0, 4'b0010);
    push_exp(HOLD + 2, "both_score1", disp(24'h000001), 1'b0, 1'b0, 1'b0, 4'b0011);
    cycles(1);
    score_valid = 1'b0; dbg_valid = 1'b0;
    cycles(HOLD + 2);

    // blink: phase toggles after 4-cycle spans of the free-running counter
    blink_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      push_exp(k, "blink", (((cyc + k - 7) % 8) < 4) ? ALL_BLANK : disp(24'h000001),
               1'b0, 1'b0, 1'b0, 4'b0001);
    end
    cycles(16);
    blink_en = 1'b0;
    push_exp(1, "blink_off", disp(24'h000001), 1'b0, 1'b0, 1'b0, 4'b0001);
    cycles(2);

    // asynchronous reset in the middle of a debug hold
    dbg_valid = 1'b1; dbg_data = 24'h123456;
    push_exp(2, "pre_reset", disp(24'h123456), 1'b1, 1'b0, 1'b0, 4'b0011);
    cycles(1);
    dbg_valid = 1'b0;
    cycles(2);
    #2;
    resetn = 1'b0;
    push_exp(-1, "async_reset", ALL_BLANK, 1'b0, 1'b0, 1'b0, 4'hF);
    now_check();
    cycles(2);
    resetn = 1'b1;
    push_exp(1, "post_reset", disp(24'h0), 1'b0, 1'b1, 1'b1, 4'hF);
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
